// File: rtl/sd_resp_rx_pkg.sv
// Shared definitions for the SD 48-bit command-response receiver.
package sd_resp_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_START = 2'd1,
    ST_RECV       = 2'd2,
    ST_DONE       = 2'd3
  } state_t;

  // Frame geometry: bit 47 is the start bit, bit 0 the end bit.
  localparam int unsigned FRAME_LEN     = 48;
  localparam int unsigned SHIFT_LEN     = FRAME_LEN - 1;  // bits after the start bit
  localparam int unsigned TX_BIT        = 46;
  localparam int unsigned INDEX_MSB     = 45;
  localparam int unsigned INDEX_LSB     = 40;
  localparam int unsigned ARG_MSB       = 39;
  localparam int unsigned ARG_LSB       = 8;
  localparam int unsigned CRC_MSB       = 7;
  localparam int unsigned CRC_LSB       = 1;
  localparam int unsigned END_BIT       = 0;
  // CRC covers frame bits 47 down to this one.
  localparam int unsigned CRC_COVER_LSB = 8;

  // One MSB-first step of CRC7, polynomial x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic inv;
    inv = b ^ c[6];
    return {c[5], c[4], c[3], c[2] ^ inv, c[1], c[0], inv};
  endfunction

endpackage

// File: rtl/sd_resp_rx_crc7_serial.sv
// Bit-serial CRC7 accumulator with synchronous clear.
module crc7_serial
  import sd_resp_rx_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_bit,
  input  logic       i_en,
  input  logic       i_clr,
  output logic [6:0] o_crc
);

  logic [6:0] r_crc;

  // Clear wins over enable so an abort never leaves a partial CRC behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_crc <= '0;
    end else if (i_clr) begin
      r_crc <= '0;
    end else if (i_en) begin
      r_crc <= crc7_step(r_crc, i_bit);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/sd_resp_rx.sv
// SD CMD-line response receiver: waits for a start bit, collects a 48-bit
// frame, checks CRC7 and framing bits, and reports the decoded fields.
module sd_resp_rx
  import sd_resp_rx_pkg::*;
#(
  parameter int unsigned NCR_MAX = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_in,
  input  logic        sample_en,
  input  logic        arm,
  input  logic        abort,
  output logic        busy,
  output logic        resp_valid,
  output logic [5:0]  resp_index,
  output logic [31:0] resp_arg,
  output logic        crc_err,
  output logic        frame_err,
  output logic        timeout_err
);

  localparam logic [7:0] NCR_LIM     = 8'(NCR_MAX);
  localparam logic [5:0] LAST_CNT    = 6'(SHIFT_LEN - 1);
  localparam logic [5:0] CRC_END_CNT = 6'(SHIFT_LEN - CRC_COVER_LSB);

  state_t r_state;
  state_t w_state_nxt;

  // Holds frame bits 46..1; the end bit is taken straight from cmd_in on its
  // strobe so the result can be captured on that same edge.
  logic [SHIFT_LEN-2:0] r_shift;
  logic [5:0]           r_bit_cnt;
  logic [7:0]           r_ncr_cnt;
  logic [5:0]           r_resp_index;
  logic [31:0]          r_resp_arg;
  logic                 r_crc_err;
  logic                 r_frame_err;
  logic                 r_timeout_err;

  logic                 w_crc_clr;
  logic                 w_crc_en;
  logic [6:0]           w_crc;
  logic                 w_cnt_clr;
  logic                 w_ncr_inc;
  logic                 w_shift_en;
  logic                 w_capture;
  logic                 w_timeout;
  logic                 w_ncr_hit;
  logic [SHIFT_LEN-1:0] w_frame;

  assign w_ncr_hit = (r_ncr_cnt + 8'd1) == NCR_LIM;
  // Indices of w_frame equal frame bit numbers 46..0.
  assign w_frame   = {r_shift, cmd_in};

  crc7_serial u_crc (
    .clk   (clk),
    .reset (reset),
    .i_bit (cmd_in),
    .i_en  (w_crc_en),
    .i_clr (w_crc_clr),
    .o_crc (w_crc)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath control; abort overrides every other input.
  always_comb begin
    w_state_nxt = r_state;
    w_crc_clr   = 1'b0;
    w_crc_en    = 1'b0;
    w_cnt_clr   = 1'b0;
    w_ncr_inc   = 1'b0;
    w_shift_en  = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_crc_clr   = 1'b1;
      w_cnt_clr   = 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (arm) begin
            w_state_nxt = ST_WAIT_START;
            w_crc_clr   = 1'b1;
            w_cnt_clr   = 1'b1;
          end
        end
        ST_WAIT_START: begin
          if (sample_en) begin
            if (!cmd_in) begin
              w_state_nxt = ST_RECV;
              w_crc_en    = 1'b1;
            end else if (w_ncr_hit) begin
              w_state_nxt = ST_IDLE;
              w_timeout   = 1'b1;
              w_cnt_clr   = 1'b1;
            end else begin
              w_ncr_inc = 1'b1;
            end
          end
        end
        ST_RECV: begin
          if (sample_en) begin
            w_shift_en = 1'b1;
            w_crc_en   = (r_bit_cnt < CRC_END_CNT);
            if (r_bit_cnt == LAST_CNT) begin
              w_state_nxt = ST_DONE;
              w_capture   = 1'b1;
            end
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Shift register and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_ncr_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_bit_cnt <= '0;
      r_ncr_cnt <= '0;
    end else begin
      if (w_ncr_inc) begin
        r_ncr_cnt <= r_ncr_cnt + 8'd1;
      end
      if (w_shift_en) begin
        r_shift   <= {r_shift[SHIFT_LEN-3:0], cmd_in};
        r_bit_cnt <= (r_bit_cnt == LAST_CNT) ? '0 : r_bit_cnt + 6'd1;
      end
    end
  end

  // Result fields, held until the next completed frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_resp_index <= '0;
      r_resp_arg   <= '0;
      r_crc_err    <= 1'b0;
      r_frame_err  <= 1'b0;
    end else if (w_capture) begin
      r_resp_index <= w_frame[INDEX_MSB:INDEX_LSB];
      r_resp_arg   <= w_frame[ARG_MSB:ARG_LSB];
      r_crc_err    <= (w_frame[CRC_MSB:CRC_LSB] != w_crc);
      r_frame_err  <= w_frame[TX_BIT] | ~w_frame[END_BIT];
    end
  end

  // Timeout pulse register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout;
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign resp_valid  = (r_state == ST_DONE);
  assign resp_index  = r_resp_index;
  assign resp_arg    = r_resp_arg;
  assign crc_err     = r_crc_err;
  assign frame_err   = r_frame_err;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_sd_resp_rx.sv
// Directed self-checking bench for sd_resp_rx.
module tb_sd_resp_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_in;
  logic        sample_en;
  logic        arm;
  logic        abort;
  logic        busy;
  logic        resp_valid;
  logic [5:0]  resp_index;
  logic [31:0] resp_arg;
  logic        crc_err;
  logic        frame_err;
  logic        timeout_err;

  int n_total = 0;
  int n_bad   = 0;
  int n_valid = 0;

  localparam logic [47:0] F_R7   = 48'h08_000001AA_13;
  localparam logic [47:0] F_CMD0 = 48'h40_00000000_95;
  localparam logic [47:0] F_BAD  = 48'h08_000001AB_13;
  localparam logic [47:0] F_ZERO = 48'h00_00000000_01;

  always #5 clk = ~clk;

  sd_resp_rx #(.NCR_MAX(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_in      (cmd_in),
    .sample_en   (sample_en),
    .arm         (arm),
    .abort       (abort),
    .busy        (busy),
    .resp_valid  (resp_valid),
    .resp_index  (resp_index),
    .resp_arg    (resp_arg),
    .crc_err     (crc_err),
    .frame_err   (frame_err),
    .timeout_err (timeout_err)
  );

  always @(posedge clk) if (resp_valid === 1'b1) n_valid++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b, input int gap);
    cmd_in    = b;
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    cmd_in    = 1'b1;
    repeat (gap) tick();
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic send_bits(input logic [47:0] f, input int hi, input int lo, input int gap);
    for (int i = hi; i >= lo; i--) strobe(f[i], gap);
  endtask

  task automatic run_frame(input string tag, input logic [47:0] f, input int gap,
                           input logic [5:0] e_idx, input logic [31:0] e_arg,
                           input logic e_crc, input logic e_frm);
    int v0;
    do_arm();
    strobe(1'b1, gap);
    strobe(1'b1, gap);
    v0 = n_valid;
    send_bits(f, 47, 1, gap);
    chk({tag, ".early"}, resp_valid, 0);
    strobe(f[0], 0);
    chk({tag, ".valid"}, resp_valid, 1);
    chk({tag, ".index"}, resp_index, e_idx);
    chk({tag, ".arg"},   resp_arg,   e_arg);
    chk({tag, ".crc"},   crc_err,    e_crc);
    chk({tag, ".frm"},   frame_err,  e_frm);
    tick();
    chk({tag, ".pulse"}, resp_valid, 0);
    chk({tag, ".idle"},  busy,       0);
    chk({tag, ".count"}, n_valid - v0, 1);
  endtask

  initial begin
    int v0;
    reset = 1'b1; cmd_in = 1'b1; sample_en = 1'b0; arm = 1'b0; abort = 1'b0;
    tick(); tick();
    chk("rst.busy",  busy,        0);
    chk("rst.valid", resp_valid,  0);
    chk("rst.index", resp_index,  0);
    chk("rst.arg",   resp_arg,    0);
    chk("rst.tmo",   timeout_err, 0);
    @(negedge clk) reset = 1'b0;
    tick();

    run_frame("r7",   F_R7,   2, 6'h08, 32'h000001AA, 1'b0, 1'b0);
    repeat (3) tick();
    chk("hold.index", resp_index, 6'h08);
    chk("hold.arg",   resp_arg,   32'h000001AA);
    run_frame("cmd0", F_CMD0, 1, 6'h00, 32'h00000000, 1'b0, 1'b1);
    run_frame("bad",  F_BAD,  0, 6'h08, 32'h000001AB, 1'b1, 1'b0);
    run_frame("zero", F_ZERO, 0, 6'h00, 32'h00000000, 1'b0, 1'b0);

    // Abort beats arm in the same clock.
    arm = 1'b1; abort = 1'b1;
    tick();
    arm = 1'b0; abort = 1'b0;
    chk("abtarm.busy", busy, 0);

    // Timeout after exactly 64 idle strobes.
    do_arm();
    for (int i = 0; i < 63; i++) strobe(1'b1, 1);
    chk("tmo.early", timeout_err, 0);
    chk("tmo.busy",  busy,        1);
    strobe(1'b1, 0);
    chk("tmo.pulse", timeout_err, 1);
    chk("tmo.idle",  busy,        0);
    tick();
    chk("tmo.clear", timeout_err, 0);

    // Abort after 20 bits.
    run_frame("pre", F_R7, 0, 6'h08, 32'h000001AA, 1'b0, 1'b0);
    v0 = n_valid;
    do_arm();
    send_bits(F_R7, 47, 28, 0);
    abort = 1'b1; sample_en = 1'b1; cmd_in = 1'b0;
    tick();
    abort = 1'b0; sample_en = 1'b0; cmd_in = 1'b1;
    chk("abt.busy", busy, 0);
    send_bits(F_R7, 27, 0, 0);
    tick();
    chk("abt.novalid", n_valid - v0, 0);
    run_frame("postabt", F_BAD, 0, 6'h08, 32'h000001AB, 1'b1, 1'b0);

    // Reset after 20 bits clears held results too.
    v0 = n_valid;
    do_arm();
    send_bits(F_R7, 47, 28, 0);
    reset = 1'b1;
    #2;
    chk("rmid.busy",  busy,       0);
    chk("rmid.index", resp_index, 0);
    chk("rmid.arg",   resp_arg,   0);
    chk("rmid.crc",   crc_err,    0);
    @(negedge clk) reset = 1'b0;
    tick();
    send_bits(F_R7, 27, 0, 0);
    tick();
    chk("rmid.novalid", n_valid - v0, 0);
    run_frame("postrst", F_R7, 1, 6'h08, 32'h000001AA, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/sd_resp_rx.md
SD_RESP_RX -- requirements
Module: sd_resp_rx

Interface
REQ-001 SHALL have parameter NCR_MAX, default 64: sample strobes to wait for a start bit before timeout; range 1..255.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port cmd_in, input, 1: serial SD CMD line, already synchronised to clk.
REQ-005 SHALL have port sample_en, input, 1: one-clk strobe per bit time; cmd_in is consumed only when it is 1.
REQ-006 SHALL have port arm, input, 1: pulse that starts waiting for a 48-bit response.
REQ-007 SHALL have port abort, input, 1: synchronous return to IDLE with no result pulse.
REQ-008 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-009 SHALL have port resp_valid, output, 1: one-clk pulse when a complete frame has been received.
REQ-010 SHALL have port resp_index, output, 6: received frame bits 45:40.
REQ-011 SHALL have port resp_arg, output, 32: received frame bits 39:8.
REQ-012 SHALL have port crc_err, output, 1: received CRC7 differs from computed; valid with resp_valid.
REQ-013 SHALL have port frame_err, output, 1: transmission bit was 1 or end bit was 0; valid with resp_valid.
REQ-014 SHALL have port timeout_err, output, 1: one-clk pulse when no start bit arrived within NCR_MAX strobes.

Function
REQ-015 SHALL implement states IDLE, WAIT_START, RECV, DONE.
REQ-016 In IDLE, arm=1 SHALL move to WAIT_START and clear the timeout counter; arm in any other state SHALL be ignored.
REQ-017 In WAIT_START, sample_en with cmd_in=0 SHALL take that bit as frame bit 47, clock it into the CRC, and move to RECV.
REQ-018 In WAIT_START, sample_en with cmd_in=1 SHALL increment the counter; on reaching NCR_MAX it SHALL pulse timeout_err and return to IDLE.
REQ-019 In RECV, each sample_en SHALL shift cmd_in MSB-first into a 47-bit register; after frame bit 0 (48th bit) it SHALL move to DONE.
REQ-020 CRC7 (x^7+x^3+1, init 0, MSB-first) SHALL be computed over frame bits 47..8 only (40 bits): inv=bit^c6; shift up; c3 gets c2^inv; c0 gets inv.
REQ-021 DONE SHALL last one clk, assert resp_valid, present fields/flags, then return to IDLE; total latency from the end-bit strobe to resp_valid is one clk.
REQ-022 crc_err SHALL be 1 iff received bits 7:1 differ from the computed CRC7; frame_err SHALL be 1 iff bit46=1 or bit0=0.
REQ-023 resp_index/resp_arg/crc_err/frame_err SHALL hold their values until the next resp_valid.
REQ-024 abort SHALL take priority over arm and sample_en in the same clk; it clears the CRC and counters.
REQ-025 sample_en=0 cycles SHALL stall all state; back-to-back strobes on consecutive clks SHALL be supported.

Reset
REQ-026 Reset SHALL force IDLE, CRC=0, counters=0, and all outputs to 0, including mid-frame.

Structure
REQ-027 A shared package SHALL hold the state encoding, frame length 48, and CRC field positions.
REQ-028 CRC computation SHALL be one sub-module crc7_serial (bit, enable, clear); the clear input is driven on arm/abort.

Verification
REQ-029 Frame 08_000001AA_13 (R7): resp_valid=1, index=0x08, arg=0x000001AA, crc_err=0, frame_err=0.
REQ-030 Frame 40_00000000_95: crc_err=0, frame_err=1 (transmission bit set).
REQ-031 R7 frame with arg bit 0 flipped (…AB_13): crc_err=1, frame_err=0.
REQ-032 Arm with cmd_in held 1, NCR_MAX=64: timeout_err pulses exactly on the 64th strobe; busy=0 next clk.
REQ-033 Abort, and separately reset, after 20 bits of a frame: no resp_valid; a following full frame decodes correctly.
REQ-034 Frame 00_00000000_01 with sample_en every clk: index=0, arg=0, no errors, resp_valid 1 clk after the end bit.
